exec_unit: RTL and testbench

Execute stage that sits directly downstream of the register file. It latches the two read operands (Rd1 and Rd2), an immediate, an opcode and a destination address on Start. It computes a single-cycle ALU result, or runs a multi-cycle shift-add multiply. It then drives the register-file write port (WE, Rw, Data) for exactly one cycle. Start/Busy/Done form the handshake to the control FSM.

---
 rtl/exec_unit_pkg.sv | 30 +++
 rtl/exec_unit_if.sv | 29 ++
 rtl/exec_unit_mul.sv | 55 +++++
 rtl/exec_unit.sv | 121 ++++++++++++
 tb/tb_exec_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_pkg.sv
// Shared types and sizing for the execute stage.
// Holds the op and state encodings, plus the multiply iteration count.
package exec_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MUL_ITERS = DATA_W;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_ADDI = 3'b011,
    OP_SUBI = 3'b100,
    OP_MULL = 3'b101,
    OP_MULH = 3'b110,
    OP_MOV  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic is_mul(input op_t op);
    return (op == OP_MULL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Handshake and register-file write-port bundle between the control FSM and the execute stage.
interface exec_if #(
  parameter int unsigned n          = 8,
  parameter int unsigned addr_width = 5
);
  logic                  Start;
  logic [2:0]            Op;
  logic [n-1:0]          A;
  logic [n-1:0]          B;
  logic [n-1:0]          Imm;
  logic [addr_width-1:0] Rd;
  logic                  Busy;
  logic                  Done;
  logic                  WE;
  logic [addr_width-1:0] Rw;
  logic [n-1:0]          Result;
  logic                  Z;
  logic                  N;

  modport master (
    output Start, Op, A, B, Imm, Rd,
    input  Busy, Done, WE, Rw, Result, Z, N
  );

  modport slave (
    input  Start, Op, A, B, Imm, Rd,
    output Busy, Done, WE, Rw, Result, Z, N
  );
endinterface

// File: rtl/exec_unit_mul.sv
// n-bit unsigned shift-add multiplier, one partial product per clock.
// product_c is the accumulator including the current iteration's addend.
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int unsigned n = MUL_ITERS
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           load,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           last_c,
  output logic [2*n-1:0] product_c
);

  localparam int unsigned CNT_W = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned PW    = 2 * n;

  logic [n-1:0]     mcand;
  logic [n-1:0]     mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    addend_c;

  always_comb begin
    addend_c  = '0;
    if (mplier[0]) addend_c = PW'(mcand) << cnt;
    product_c = acc + addend_c;
    last_c    = (cnt == CNT_W'(n - 1));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load && !busy) begin
      busy   <= 1'b1;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product_c;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops or sequential multiply, then one register-file write cycle.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned n          = DATA_W,
  parameter int unsigned addr_width = ADDR_W
) (
  input  logic  Clock,
  input  logic  Reset,
  exec_if.slave bus
);

  state_t                state, state_nx;
  op_t                   op_q, op_nx, op_in_c;
  logic                  busy_nx, done_nx, we_nx, z_nx, n_nx;
  logic [addr_width-1:0] rw_nx;
  logic [n-1:0]          result_nx, alu_c;
  logic                  mul_load_c, mul_busy, mul_last_c;
  logic [2*n-1:0]        mul_prod_c;

  seq_multiplier #(.n(n)) u_mul (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (mul_load_c),
    .a         (bus.A),
    .b         (bus.B),
    .busy      (mul_busy),
    .last_c    (mul_last_c),
    .product_c (mul_prod_c)
  );

  // Single-cycle datapath, evaluated on the live operands at the accepting edge
  always_comb begin
    op_in_c = op_t'(bus.Op);
    alu_c   = '0;
    case (op_in_c)
      OP_ADD:  alu_c = bus.A + bus.B;
      OP_SUB:  alu_c = bus.A - bus.B;
      OP_ADDI: alu_c = bus.A + bus.Imm;
      OP_SUBI: alu_c = bus.A - bus.Imm;
      OP_MOV:  alu_c = bus.B;
      default: alu_c = '0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    we_nx      = 1'b0;
    rw_nx      = bus.Rw;
    result_nx  = bus.Result;
    z_nx       = bus.Z;
    n_nx       = bus.N;
    mul_load_c = 1'b0;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          op_nx   = op_in_c;
          rw_nx   = bus.Rd;
          busy_nx = 1'b1;
          if (is_mul(op_in_c)) begin
            mul_load_c = 1'b1;
            state_nx   = MULT;
          end else begin
            state_nx = WB;
            done_nx  = 1'b1;
            if (op_in_c != OP_NOP) begin
              we_nx     = 1'b1;
              result_nx = alu_c;
            end
          end
        end
      end
      MULT: begin
        busy_nx = 1'b1;
        if (mul_busy && mul_last_c) begin
          state_nx  = WB;
          done_nx   = 1'b1;
          we_nx     = 1'b1;
          result_nx = (op_q == OP_MULH) ? mul_prod_c[2*n-1:n] : mul_prod_c[n-1:0];
        end
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Flags track only results that are actually written
    if (we_nx) begin
      z_nx = (result_nx == '0);
      n_nx = result_nx[n-1];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      bus.Busy   <= 1'b0;
      bus.Done   <= 1'b0;
      bus.WE     <= 1'b0;
      bus.Rw     <= '0;
      bus.Result <= '0;
      bus.Z      <= 1'b0;
      bus.N      <= 1'b0;
    end else begin
      state      <= state_nx;
      op_q       <= op_nx;
      bus.Busy   <= busy_nx;
      bus.Done   <= done_nx;
      bus.WE     <= we_nx;
      bus.Rw     <= rw_nx;
      bus.Result <= result_nx;
      bus.Z      <= z_nx;
      bus.N      <= n_nx;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, reset abort sequence,
// then random operations checked against an arithmetic reference model.
module tb_exec_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  exec_if #(.n(8), .addr_width(5)) bus ();

  exec_unit #(.n(8), .addr_width(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [4:0] rd;
    bit         poke;
    logic [7:0] res;
    bit         we;
    bit         z;
    bit         n;
  } vec_t;

  int total = 0;
  int bad   = 0;
  bit model_z = 1'b0;
  bit model_n = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] imm, input logic [4:0] rd, input bit poke,
                              input logic [7:0] res, input bit we, input bit z, input bit n);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.poke = poke;
    v.res = res; v.we = we; v.z = z; v.n = n;
    return v;
  endfunction

  // Reference: plain integer arithmetic from the op definitions
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] imm, input logic [4:0] rd, input bit poke);
    vec_t v;
    int   r;
    int   ia, ib, ii;
    ia = int'(a); ib = int'(b); ii = int'(imm);
    case (op)
      3'd1:    r = (ia + ib) % 256;
      3'd2:    r = (ia - ib + 256) % 256;
      3'd3:    r = (ia + ii) % 256;
      3'd4:    r = (ia - ii + 256) % 256;
      3'd5:    r = (ia * ib) % 256;
      3'd6:    r = (ia * ib) / 256;
      3'd7:    r = ib;
      default: r = 0;
    endcase
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.poke = poke;
    v.we  = (op != 3'd0);
    v.res = 8'(r);
    v.z   = v.we ? (r == 0) : model_z;
    v.n   = v.we ? (r >= 128) : model_n;
    return v;
  endfunction

  // Issue one op from IDLE; operands are scrambled right after acceptance
  task automatic run_op(input vec_t v);
    int lat;
    lat = (v.op == 3'd5 || v.op == 3'd6) ? 8 : 0;
    check("idle_busy", 32'(bus.Busy), 32'd0);
    bus.Start = 1'b1; bus.Op = v.op; bus.A = v.a; bus.B = v.b; bus.Imm = v.imm; bus.Rd = v.rd;
    @(posedge Clock); #1;
    bus.Start = v.poke;
    bus.Op    = 3'd1;
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
    bus.Imm   = 8'($urandom);
    bus.Rd    = 5'($urandom);
    for (int c = 0; c < lat; c++) begin
      check("mult_busy", 32'(bus.Busy), 32'd1);
      check("mult_we",   32'(bus.WE),   32'd0);
      check("mult_done", 32'(bus.Done), 32'd0);
      @(posedge Clock); #1;
    end
    check("wb_done", 32'(bus.Done), 32'd1);
    check("wb_busy", 32'(bus.Busy), 32'd1);
    check("wb_we",   32'(bus.WE),   32'(v.we));
    check("wb_rw",   32'(bus.Rw),   32'(v.rd));
    if (v.we) check("wb_result", 32'(bus.Result), 32'(v.res));
    check("wb_z", 32'(bus.Z), 32'(v.z));
    check("wb_n", 32'(bus.N), 32'(v.n));
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    check("post_busy", 32'(bus.Busy), 32'd0);
    check("post_done", 32'(bus.Done), 32'd0);
    check("post_we",   32'(bus.WE),   32'd0);
    @(posedge Clock); #1;
    check("post2_done", 32'(bus.Done), 32'd0);
    if (v.we) check("post2_result", 32'(bus.Result), 32'(v.res));
    model_z = v.z;
    model_n = v.n;
  endtask

  vec_t tbl[12];
  int   we_seen;

  initial begin
    bus.Start = 1'b0; bus.Op = 3'd0; bus.A = '0; bus.B = '0; bus.Imm = '0; bus.Rd = '0;

    #12;
    check("rst_busy",   32'(bus.Busy),   32'd0);
    check("rst_done",   32'(bus.Done),   32'd0);
    check("rst_we",     32'(bus.WE),     32'd0);
    check("rst_rw",     32'(bus.Rw),     32'd0);
    check("rst_result", 32'(bus.Result), 32'd0);
    check("rst_z",      32'(bus.Z),      32'd0);
    check("rst_n",      32'(bus.N),      32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    //           op    a      b      imm    rd  poke res    we z  n
    tbl[0]  = mk(3'd1, 8'h7F, 8'h01, 8'h00, 3,  0,  8'h80, 1, 0, 1);
    tbl[1]  = mk(3'd2, 8'h05, 8'h05, 8'h00, 4,  0,  8'h00, 1, 1, 0);
    tbl[2]  = mk(3'd0, 8'h00, 8'h00, 8'h00, 9,  0,  8'h00, 0, 1, 0);
    tbl[3]  = mk(3'd6, 8'hFF, 8'hFF, 8'h00, 7,  1,  8'hFE, 1, 0, 1);
    tbl[4]  = mk(3'd5, 8'hFF, 8'hFF, 8'h00, 7,  0,  8'h01, 1, 0, 0);
    tbl[5]  = mk(3'd5, 8'h0C, 8'h0A, 8'h00, 12, 0,  8'h78, 1, 0, 0);
    tbl[6]  = mk(3'd1, 8'h01, 8'h02, 8'h00, 1,  1,  8'h03, 1, 0, 0);
    tbl[7]  = mk(3'd3, 8'h10, 8'h00, 8'hF0, 2,  0,  8'h00, 1, 1, 0);
    tbl[8]  = mk(3'd4, 8'h10, 8'h00, 8'h20, 5,  0,  8'hF0, 1, 0, 1);
    tbl[9]  = mk(3'd7, 8'h00, 8'h5A, 8'h00, 31, 0,  8'h5A, 1, 0, 0);
    tbl[10] = mk(3'd2, 8'h00, 8'h01, 8'h00, 6,  0,  8'hFF, 1, 0, 1);
    tbl[11] = mk(3'd6, 8'h0C, 8'h0A, 8'h00, 8,  0,  8'h00, 1, 1, 0);
    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Leave N=1 so the abort visibly clears the flags
    run_op(mk(3'd6, 8'hFF, 8'hFF, 8'h00, 7, 0, 8'hFE, 1, 0, 1));
    bus.Start = 1'b1; bus.Op = 3'd5; bus.A = 8'hFF; bus.B = 8'hFF; bus.Rd = 5'd11;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_we",   32'(bus.WE),   32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_z",    32'(bus.Z),    32'd0);
    check("abort_n",    32'(bus.N),    32'd0);
    @(posedge Clock); #1;
    Reset   = 1'b0;
    model_z = 1'b0;
    model_n = 1'b0;
    we_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.WE || bus.Done) we_seen++;
      @(posedge Clock); #1;
    end
    check("abort_no_write", 32'(we_seen), 32'd0);
    run_op(mk(3'd3, 8'h10, 8'h00, 8'hF0, 2, 0, 8'h00, 1, 1, 0));

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] a, b, imm;
      logic [4:0] rd;
      bit         poke;
      op   = 3'($urandom_range(0, 7));
      a    = 8'($urandom);
      b    = 8'($urandom);
      imm  = 8'($urandom);
      rd   = 5'($urandom);
      poke = 1'($urandom);
      run_op(model(op, a, b, imm, rd, poke));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
